// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter with locked sequences sharing one synchronous data memory between two ports.
module dmem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic              r0_lock,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic              r1_lock,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r0_gnt,
   output logic              r1_gnt,
   output logic              r0_rvalid,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   typedef enum logic [1:0] {FREE, LOCK0, LOCK1} state_t;
   state_t state, state_nx;
   logic   last, rv0, rv1;
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state <= FREE;
         last  <= 1'b1;
         rv0   <= 1'b0;
         rv1   <= 1'b0;
      end else begin
         state <= state_nx;
         last  <= r0_gnt ? 1'b0 : r1_gnt ? 1'b1 : last;
         rv0   <= r0_gnt && !r0_we;
         rv1   <= r1_gnt && !r1_we;
      end
   end
   // in FREE a conflict goes to the port that did not win last
   always_comb begin
      r0_gnt    = Reset_n && r0_req && (state == LOCK0 || (state == FREE && (!r1_req || last)));
      r1_gnt    = Reset_n && r1_req && (state == LOCK1 || (state == FREE && (!r0_req || !last)));
      state_nx  = r0_gnt ? (r0_lock ? LOCK0 : FREE) : r1_gnt ? (r1_lock ? LOCK1 : FREE) : state;
      mem_en    = r0_gnt || r1_gnt;
      mem_we    = r0_gnt ? r0_we : r1_gnt ? r1_we : 1'b0;
      mem_addr  = r0_gnt ? r0_addr : r1_gnt ? r1_addr : '0;
      mem_wdata = r0_gnt ? r0_wdata : r1_gnt ? r1_wdata : '0;
      r0_rvalid = rv0;
      r1_rvalid = rv1;
      r0_rdata  = rv0 ? mem_rdata : '0;
      r1_rdata  = rv1 ? mem_rdata : '0;
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven check of dmem_arbiter with a scoreboard of expected read data.
module tb_dmem_arbiter;
   logic        Clock = 1'b0;
   logic        Reset_n = 1'b0;
   logic        r0_req = 0, r0_we = 0, r0_lock = 0, r1_req = 0, r1_we = 0, r1_lock = 0;
   logic [7:0]  r0_addr = 0, r1_addr = 0;
   logic [15:0] r0_wdata = 0, r1_wdata = 0;
   logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_en, mem_we;
   logic [15:0] r0_rdata, r1_rdata, mem_wdata, mem_rdata;
   logic [7:0]  mem_addr;
   logic [15:0] mem [256];
   logic [15:0] shadow [256];
   logic [15:0] mem_q = 0;
   int          n_vec = 0, n_cmp = 0, n_fail = 0;
   logic        prv0 = 0, prv1 = 0;
   typedef struct {
      logic rst; logic q0, w0, l0; logic [7:0] a0; logic [15:0] d0;
      logic q1, w1, l1; logic [7:0] a1; logic [15:0] d1; logic g0, g1;
   } vec_t;
   typedef struct {logic port; logic [15:0] data;} rd_t;
   vec_t vt[$];
   rd_t  sb[$];

   dmem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
      .Clock(Clock), .Reset_n(Reset_n),
      .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
      .r0_rdata(r0_rdata), .r1_rdata(r1_rdata), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 Clock = ~Clock;
   assign mem_rdata = mem_q;
   always @(posedge Clock)
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else mem_q <= mem[mem_addr];
      end

   function automatic vec_t mk(input logic rst, q0, w0, l0, input logic [7:0] a0, input logic [15:0] d0,
                               input logic q1, w1, l1, input logic [7:0] a1, input logic [15:0] d1,
                               input logic g0, g1);
      vec_t v;
      v.rst = rst; v.q0 = q0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
      v.q1 = q1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1; v.g0 = g0; v.g1 = g1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL vec %0d %s: got %h expected %h", n_vec, name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      rd_t r;
      @(negedge Clock);
      Reset_n = v.rst;
      r0_req = v.q0; r0_we = v.w0; r0_lock = v.l0; r0_addr = v.a0; r0_wdata = v.d0;
      r1_req = v.q1; r1_we = v.w1; r1_lock = v.l1; r1_addr = v.a1; r1_wdata = v.d1;
      #2;
      n_vec++;
      chk("r0_gnt", r0_gnt, v.g0);
      chk("r1_gnt", r1_gnt, v.g1);
      chk("mem_en", mem_en, v.g0 | v.g1);
      chk("mem_we", mem_we, v.g0 ? v.w0 : v.g1 ? v.w1 : 1'b0);
      chk("mem_addr", mem_addr, v.g0 ? v.a0 : v.g1 ? v.a1 : 8'h0);
      chk("mem_wdata", mem_wdata, v.g0 ? v.d0 : v.g1 ? v.d1 : 16'h0);
      chk("r0_rvalid", r0_rvalid, prv0);
      chk("r1_rvalid", r1_rvalid, prv1);
      if (prv0 || prv1) begin
         if (sb.size() == 0) chk("scoreboard_empty", 1, 0);
         else begin
            r = sb.pop_front();
            chk("rd_port", prv1, r.port);
            chk(r.port ? "r1_rdata" : "r0_rdata", r.port ? r1_rdata : r0_rdata, r.data);
         end
      end
      if (!prv0) chk("r0_rdata_idle", r0_rdata, 0);
      if (!prv1) chk("r1_rdata_idle", r1_rdata, 0);
      if (v.g0 && !v.w0) sb.push_back('{1'b0, shadow[v.a0]});
      if (v.g1 && !v.w1) sb.push_back('{1'b1, shadow[v.a1]});
      if (v.g0 && v.w0) shadow[v.a0] = v.d0;
      if (v.g1 && v.w1) shadow[v.a1] = v.d1;
      prv0 = v.g0 && !v.w0;
      prv1 = v.g1 && !v.w1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = 16'(i * 16'h0101) ^ 16'hA5A5;
         shadow[i] = mem[i];
      end
      mem[8'h10] = 16'hBEEF;
      shadow[8'h10] = 16'hBEEF;
      // reset gates grants even with requests present
      vt.push_back(mk(0, 1,0,0,8'h10,0, 1,1,0,8'h11,16'h7777, 0,0));
      vt.push_back(mk(0, 1,0,0,8'h10,0, 1,1,0,8'h11,16'h7777, 0,0));
      vt.push_back(mk(1, 1,0,0,8'h10,0, 0,0,0,0,0, 1,0));
      vt.push_back(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0));
      vt.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0));
      for (int i = 0; i < 6; i++)
         vt.push_back(mk(1, 1,0,0,8'h11,0, 1,0,0,8'h12,0, i % 2 == 0, i % 2 == 1));
      // locked read-modify-write by r0 blocks r1's write
      vt.push_back(mk(1, 1,0,1,8'h20,0, 1,1,0,8'h20,16'h1234, 1,0));
      vt.push_back(mk(1, 1,1,0,8'h20,16'h0001, 1,1,0,8'h20,16'h1234, 1,0));
      vt.push_back(mk(1, 0,0,0,0,0, 1,1,0,8'h20,16'h1234, 0,1));
      vt.push_back(mk(1, 1,0,0,8'h20,0, 0,0,0,0,0, 1,0));
      // LOCK1 held while r1 is idle
      vt.push_back(mk(1, 0,0,0,0,0, 1,0,1,8'h30,0, 0,1));
      for (int i = 0; i < 3; i++) vt.push_back(mk(1, 1,0,0,8'h10,0, 0,0,0,0,0, 0,0));
      vt.push_back(mk(1, 1,0,0,8'h10,0, 1,1,0,8'h31,16'h5555, 0,1));
      vt.push_back(mk(1, 1,0,0,8'h10,0, 0,0,0,0,0, 1,0));
      // reset right after an r1 read grant
      vt.push_back(mk(1, 0,0,0,0,0, 1,0,0,8'h12,0, 0,1));
      vt.push_back(mk(0, 0,0,0,0,0, 1,0,0,8'h12,0, 0,0));
      vt.push_back(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0));
      // reset during LOCK0 with last=0: next conflict must go to r0
      vt.push_back(mk(1, 1,0,1,8'h10,0, 0,0,0,0,0, 1,0));
      vt.push_back(mk(0, 1,0,1,8'h10,0, 1,0,0,8'h12,0, 0,0));
      vt.push_back(mk(1, 1,0,0,8'h11,0, 1,0,0,8'h12,0, 1,0));
      vt.push_back(mk(1, 1,0,0,8'h11,0, 1,0,0,8'h12,0, 0,1));
      // reset releases LOCK0 so a lone r1 is granted
      vt.push_back(mk(1, 1,0,1,8'h10,0, 0,0,0,0,0, 1,0));
      vt.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0));
      vt.push_back(mk(1, 0,0,0,0,0, 1,0,0,8'h12,0, 0,1));
      foreach (vt[i]) apply(vt[i]);
      // back-to-back locked reads by r0 while r1 waits
      for (int i = 0; i < 4; i++)
         apply(mk(1, 1,0,(i < 3),8'(8'h40 + i),0, 1,1,0,8'h50,16'hCAFE, 1,0));
      apply(mk(1, 0,0,0,0,0, 1,1,0,8'h50,16'hCAFE, 0,1));
      apply(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0));
      @(negedge Clock);
      chk("mem_20_final", mem[8'h20], 16'h1234);
      chk("mem_31_final", mem[8'h31], 16'h5555);
      chk("mem_50_final", mem[8'h50], 16'hCAFE);
      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port synchronous 16-bit data memory between the CPU load/store path (port 0) and the program-loader/debug port (port 1). It grants at most one access per Clock cycle using round-robin priority. It supports locked sequences (atomic read-modify-write) and returns read data one cycle after grant. It sits between the CPU top level and the data memory instance; the CPU stalls while its request is not granted.

## Interface
- ADDR_W, 8, memory word-address width
- DATA_W, 16, data word width
- Clock  in  1  system clock; all state updates on rising edge
- Reset_n  in  1  synchronous, active-low reset, sampled on rising edge of Clock
- r0_req / r1_req  in  1  access request; held until granted
- r0_we / r1_we  in  1  1 = write, 0 = read
- r0_lock / r1_lock  in  1  keep ownership after this access
- r0_addr / r1_addr  in  ADDR_W  word address
- r0_wdata / r1_wdata  in  DATA_W  write data
- r0_gnt / r1_gnt  out  1  access performed this cycle (combinational)
- r0_rvalid / r1_rvalid  out  1  read data valid (registered)
- r0_rdata / r1_rdata  out  DATA_W  read data; 0 when rvalid=0
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe

## Operation
- State: owner FSM {FREE, LOCK0, LOCK1}; last-grant pointer `last` (1 bit); rvalid pipeline regs rv0, rv1.
- FREE:
  - only one req: grant it.
  - both req: grant the port != last.
  - none: mem_en=0.
- LOCK0: only r0 may be granted. r1_gnt=0 regardless of r1_req. Same for LOCK1 with r1.
- On a grant to port k:
  - mem_en=1; mem_we, mem_addr, mem_wdata are taken from port k.
  - last <= k.
  - If rk_lock=1, next state LOCKk; else next state FREE.
- In LOCKk with rk_req=0: state holds, memory idle (the lock persists until port k issues a granted access with lock=0).
- Read grant to port k in cycle N: rvk=1 in cycle N+1. rk_rdata = mem_rdata while rvk=1, else 0.
- Write grant: no rvalid.
- Outputs are never granted to both ports in one cycle; mem_* = 0 when no grant.
- Reset (Reset_n=0 at edge):
  - state=FREE, last=1 (port 0 wins first conflict), rv0=rv1=0.
  - All gnt combinationally 0 while Reset_n=0.
  - A read granted in the cycle before reset produces no rvalid after reset.
  - An in-progress lock is released.

## Timing
- Grant latency: 0 cycles (gnt same cycle as req when eligible).
- Read data latency: 1 cycle after grant; back-to-back reads by the same port give rvalid every cycle.
- Worst-case wait in FREE with both requesting continuously: 1 cycle (strict alternation).
- Lock can starve the other port indefinitely; bounding lock length is the requester's responsibility.
- Requester must hold req/we/addr/wdata/lock stable until the gnt cycle. Changes before grant are allowed and take effect immediately.
- Simultaneous grant-with-lock=0 and arrival of the other port's req: the other port is eligible from the next cycle.

## Test plan
- Reset then only r0 reads addr 0x10 (mem holds 0xBEEF) -> r0_gnt=1 same cycle, mem_addr=0x10, mem_en=1, mem_we=0. Next cycle r0_rvalid=1, r0_rdata=0xBEEF; r1 outputs stay 0.
- Both ports request reads continuously from reset for 6 cycles -> grants alternate r0, r1, r0, r1, r0, r1. Each rvalid follows its grant by exactly one cycle.
- r0 read 0x20 with lock=1, r1 requesting write 0x20 <= 0x1234, then r0 write 0x20 <= 0x0001 with lock=0 -> r1_gnt=0 for both r0 cycles. r1 is granted the following cycle. Final mem[0x20]=0x1234.
- LOCK1 entered, r1 drops req for 3 cycles while r0 requests -> r0_gnt stays 0, mem_en=0. r1 write with lock=0 releases; r0 granted next cycle.
- Reset_n asserted low in the cycle after an r1 read grant, also during LOCK0 -> r1_rvalid=0 after reset, state FREE. First subsequent conflict granted to r0.
